numrecog_match_ctrl: RTL
========================

# numrecog_match_ctrl

Sequencer that time-shares the digit-template ROMs (prom_0..prom_9, 16x16 bitmaps, combinational row read) against a captured 16x16 drawn image. On `start` it walks every template row by row, scores per-pixel agreement, and reports the best-matching digit and its score. It sits between the image frame buffer and the template ROM bank, and drives the ROM select mux and row address.

## Interface

Parameters:
- NUM_DIGITS, 10: templates scanned, indices 0..NUM_DIGITS-1 (max 15).
- MIN_SCORE, 0: best score below this is rejected; the digit reports 4'hF.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: level-sampled request; accepted only in IDLE.
- rom_sel, out, 4: template index driving the ROM bank mux.
- row_addr, out, 4: row index to the ROM `addr` and the image buffer.
- rom_row, in, 16: selected template row, valid in the same cycle (combinational).
- img_row, in, 16: image row at `row_addr`, valid in the same cycle.
- busy, out, 1: high from the cycle after start acceptance through the DONE cycle.
- done, out, 1: one-cycle pulse when the result is updated.
- valid, out, 1: result held valid; cleared on the next start acceptance.
- digit, out, 4: best digit, or 4'hF on reject.
- score, out, 9: best total matching-pixel count, 0..256.

## Operation

- States: IDLE, SCAN, FLUSH, DONE.
- IDLE -> SCAN when `start`=1 at the edge. On that edge:
  - clear `valid`, the accumulator and the best registers;
  - set `rom_sel`=0 and `row_addr`=0.
- SCAN runs one (digit, row) pair per cycle:
  - `row_addr` increments 0..15; on wrap to 0, `rom_sel` increments.
  - After digit NUM_DIGITS-1, row 15, go to FLUSH.
- Row match is popcount(~(rom_row ^ img_row)), 5 bits, 0..16.
  - It is registered into a pipe register together with a last-row flag (row==15).
- Accumulate stage, using the pipe register from the previous cycle:
  - acc (9 bits) += pipe value.
  - On last-row, the candidate is acc + pipe value, and acc resets to 0.
  - Digit 0's candidate always loads best. Later candidates replace best only if strictly greater, so ties keep the lower digit.
  - No overflow: max 16x16 = 256 fits in 9 bits.
- FLUSH: one cycle to consume the final pipe entry, then go to DONE.
- Result registers load at the FLUSH->DONE edge:
  - `score` = best score;
  - `digit` = best digit, or 4'hF if best < MIN_SCORE;
  - `valid` = 1.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored in SCAN, FLUSH and DONE. No queuing.
- `rom_sel`/`row_addr` hold their last values in IDLE.
- Reset values, asserted immediately and asynchronously:
  - state IDLE;
  - `busy`, `done`, `valid` = 0;
  - `rom_sel`, `row_addr`, `digit` = 0;
  - `score` = 0;
  - pipe, acc and best cleared.
- Reset mid-scan aborts with no partial result. The next start runs a full scan.

## Timing

- Let E0 be the edge where `start` is accepted. Cycle n is the cycle after edge En-1 (cycle 1 follows E0).
- Cycles 1..16*NUM_DIGITS: SCAN, one address pair per cycle, `busy`=1.
- Cycle 16*NUM_DIGITS+1: FLUSH.
- Cycle 16*NUM_DIGITS+2 (162 for default): `done`=1; `digit`/`score`/`valid` are already updated.
- Back-to-back: with `start` held high, the next acceptance is at the edge ending the first IDLE cycle after DONE. The period is 16*NUM_DIGITS+3 cycles.
- The upstream image must stay stable from E0 through the last SCAN cycle.

## Test plan

- Image = exact digit-7 bitmap, real templates -> `digit`=7, `score`=256, `done` in cycle 162 only, `busy` high cycles 1..162.
- ROM stub with all ten templates identical, image arbitrary -> `digit`=0 (tie rule), `score` equals the single-template popcount.
- Stub where templates 3 and 8 both score 200 and all others are below 200 -> `digit`=3, `score`=200.
- MIN_SCORE=240, image = digit 7 with 20 pixels flipped, other templates below 236 -> `digit`=4'hF, `score`=236, `valid`=1.
- `rst` pulsed in cycle 50 of SCAN:
  - all outputs 0 immediately, state IDLE;
  - a later start completes normally with 162-cycle latency and a correct result.
- `start` held high continuously; also pulsed during SCAN -> mid-scan pulses ignored, runs repeat every 163 cycles, `valid` drops at each new acceptance.

Source files
------------

// File: rtl/numrecog_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : numrecog_match_ctrl
// Description : Time-shares the digit-template ROM bank against a captured
//               16x16 image. Walks every (template, row) pair once per start,
//               scores per-pixel agreement and reports the best digit/score.
// Revision    : 1.0 - initial release
// ============================================================================
module numrecog_match_ctrl #(
    parameter int NUM_DIGITS = 10,
    parameter int MIN_SCORE  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  rom_sel,
    output logic [3:0]  row_addr,
    input  logic [15:0] rom_row,
    input  logic [15:0] img_row,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [3:0]  digit,
    output logic [8:0]  score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_last_sel  = 4'(NUM_DIGITS - 1);
    localparam logic [9:0] c_min_score = 10'(MIN_SCORE);

    state_t      r_state;
    state_t      w_state_next;

    logic        w_accept;
    logic        w_last_pair;
    logic [15:0] w_agree;
    logic [4:0]  w_match;

    logic        r_pipe_vld;
    logic        r_pipe_last;
    logic [4:0]  r_pipe_val;
    logic [3:0]  r_pipe_sel;

    logic [8:0]  r_acc;
    logic [8:0]  r_best;
    logic [3:0]  r_best_sel;
    logic [8:0]  w_cand;
    logic        w_take;
    logic [8:0]  w_best_next;
    logic [3:0]  w_best_sel_next;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_last_pair = (r_state == S_SCAN) && (rom_sel == c_last_sel) && (row_addr == 4'hF);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: scan every pair, one flush cycle, one done cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SCAN;
            S_SCAN:  if (w_last_pair) w_state_next = S_FLUSH;
            S_FLUSH: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address walker: row is the fast index, template the slow one; holds after the last pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_sel  <= 4'd0;
            row_addr <= 4'd0;
        end else if (w_accept) begin
            rom_sel  <= 4'd0;
            row_addr <= 4'd0;
        end else if ((r_state == S_SCAN) && !w_last_pair) begin
            row_addr <= row_addr + 4'd1;
            if (row_addr == 4'hF) begin
                rom_sel <= rom_sel + 4'd1;
            end
        end
    end

    // Row agreement count: number of pixels where template and image match
    always_comb begin
        w_agree = ~(rom_row ^ img_row);
        w_match = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_match = w_match + 5'(w_agree[i]);
        end
    end

    // Pipe register: row score plus the tags the accumulate stage needs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld  <= 1'b0;
            r_pipe_last <= 1'b0;
            r_pipe_val  <= 5'd0;
            r_pipe_sel  <= 4'd0;
        end else begin
            r_pipe_vld  <= (r_state == S_SCAN);
            r_pipe_last <= (row_addr == 4'hF);
            r_pipe_val  <= w_match;
            r_pipe_sel  <= rom_sel;
        end
    end

    // Candidate compare: template 0 always seeds best, later ones must beat it strictly
    always_comb begin
        w_cand          = r_acc + {4'd0, r_pipe_val};
        w_take          = r_pipe_vld && r_pipe_last && ((r_pipe_sel == 4'd0) || (w_cand > r_best));
        w_best_next     = w_take ? w_cand : r_best;
        w_best_sel_next = w_take ? r_pipe_sel : r_best_sel;
    end

    // Accumulator and running best, both cleared when a new scan is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= 9'd0;
            r_best     <= 9'd0;
            r_best_sel <= 4'd0;
        end else if (w_accept) begin
            r_acc      <= 9'd0;
            r_best     <= 9'd0;
            r_best_sel <= 4'd0;
        end else begin
            if (r_pipe_vld) begin
                r_acc <= r_pipe_last ? 9'd0 : w_cand;
            end
            r_best     <= w_best_next;
            r_best_sel <= w_best_sel_next;
        end
    end

    // Result registers: the FLUSH cycle folds in the final row, so load from the next-best values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            digit <= 4'd0;
            score <= 9'd0;
        end else if (w_accept) begin
            valid <= 1'b0;
        end else if (r_state == S_FLUSH) begin
            score <= w_best_next;
            digit <= ({1'b0, w_best_next} < c_min_score) ? 4'hF : w_best_sel_next;
            valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire
